// File: rtl/video_pkg.sv
// Shared video/AXI definitions for the HDMI frame fetch path.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    ADDR,
    DATA
  } fetch_state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int BYTES_PER_PIXEL = 2;

endpackage

// File: rtl/hdmi_burst_fetcher_if.sv
// AXI4 read channels plus display-FIFO write port used by hdmi_burst_fetcher.
interface hdmi_burst_fetcher_if #(
  parameter int DATA_W = 64
) ();

  logic [31:0]       ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic              RLAST;
  logic              fifo_prog_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;

  modport master (
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY, fifo_wr_en, fifo_wr_data,
    input  ARREADY, RDATA, RVALID, RLAST, fifo_prog_full
  );

  modport slave (
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY, fifo_wr_en, fifo_wr_data,
    output ARREADY, RDATA, RVALID, RLAST, fifo_prog_full
  );

endinterface

// File: rtl/hdmi_burst_fetcher_stats.sv
// Frame-completion and late-frame-start counters for hdmi_burst_fetcher.
module fetch_stats (
  input  logic        clk_100Mhz,
  input  logic        sys_rst_n,
  input  logic        frame_done,
  input  logic        frame_late,
  output logic [15:0] frame_cnt,
  output logic [15:0] late_cnt
);

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      late_cnt  <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (frame_late) late_cnt  <= late_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/hdmi_burst_fetcher.sv
// AXI4 read-burst master streaming one stored frame into the display FIFO.
// Statistics counters are built only when BURST_FETCH_STATS_EN is defined.
module hdmi_burst_fetcher
  import video_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FRAME_BYTES = H_ACTIVE * V_ACTIVE * BYTES_PER_PIXEL,
  parameter int          BURST_LEN   = 16,
  parameter int          DATA_W      = 64
) (
  input  logic                 clk_100Mhz,
  input  logic                 sys_rst_n,
  input  logic                 frame_start,
  hdmi_burst_fetcher_if.master bus,
  output logic                 busy,
  output logic                 rlast_err,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          late_cnt
);

  localparam int OFF_W  = $clog2(FRAME_BYTES);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [OFF_W-1:0]  STEP       = OFF_W'(BURST_LEN * 8);
  localparam logic [OFF_W-1:0]  LAST_OFF   = OFF_W'(FRAME_BYTES - BURST_LEN * 8);
  localparam logic [BEAT_W-1:0] FINAL_BEAT = BEAT_W'(BURST_LEN - 1);

  fetch_state_t      state;
  logic [OFF_W-1:0]  offset;
  logic [BEAT_W-1:0] beat_cnt;
  logic              restart_pend;
  logic              arvalid;
  logic              rready;
  logic              beat;
  logic              last_beat;
  logic              late_start;
  logic              restart;
  logic              vld_p1;
  logic [DATA_W-1:0] wr_data_p1;

  assign beat       = (state == DATA) && bus.RVALID && rready;
  assign last_beat  = beat && bus.RLAST;
  assign late_start = frame_start && (state != IDLE);
  // A frame_start coinciding with RLAST restarts right away instead of pending.
  assign restart    = restart_pend || frame_start;

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      offset       <= '0;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      busy         <= 1'b0;
      rlast_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          offset <= '0;
          busy   <= 1'b1;
          state  <= GATE;
        end
        GATE: if (!bus.fifo_prog_full) begin
          arvalid <= 1'b1;
          state   <= ADDR;
        end
        ADDR: if (bus.ARREADY) begin
          arvalid  <= 1'b0;
          rready   <= 1'b1;
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (beat) begin
          // Saturate so a runaway burst cannot alias back onto the final beat.
          if (beat_cnt != '1) beat_cnt <= beat_cnt + BEAT_W'(1);
          if (bus.RLAST != (beat_cnt == FINAL_BEAT)) rlast_err <= 1'b1;
          if (bus.RLAST) begin
            rready <= 1'b0;
            if (restart) begin
              offset       <= '0;
              restart_pend <= 1'b0;
              state        <= GATE;
            end else if (offset == LAST_OFF) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              offset <= offset + STEP;
              state  <= GATE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (late_start && !last_beat) restart_pend <= 1'b1;
    end
  end

  // Stage p1: accepted beat is registered into the FIFO write port.
  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1     <= 1'b0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= beat;
      if (beat) wr_data_p1 <= bus.RDATA;
    end
  end

  assign bus.ARADDR       = BASE_ADDR + 32'(offset);
  assign bus.ARVALID      = arvalid;
  assign bus.ARLEN        = 8'(BURST_LEN - 1);
  assign bus.ARSIZE       = AXI_SIZE_8B;
  assign bus.ARBURST      = AXI_BURST_INCR;
  assign bus.RREADY       = rready;
  assign bus.fifo_wr_en   = vld_p1;
  assign bus.fifo_wr_data = wr_data_p1;

`ifdef BURST_FETCH_STATS_EN
  logic frame_done;

  assign frame_done = last_beat && !restart && (offset == LAST_OFF);

  fetch_stats u_stats (
    .clk_100Mhz (clk_100Mhz),
    .sys_rst_n  (sys_rst_n),
    .frame_done (frame_done),
    .frame_late (late_start),
    .frame_cnt  (frame_cnt),
    .late_cnt   (late_cnt)
  );
`else
  assign frame_cnt = '0;
  assign late_cnt  = '0;
`endif

endmodule
